sample_pack_ctrl: RTL and testbench

SAMPLE_PACK_CTRL -- requirements
Module: sample_pack_ctrl

---
 rtl/sample_pkg.sv | 13 +
 rtl/sample_pack_ctrl_tick_gen.sv | 29 ++
 rtl/sample_pack_ctrl.sv | 110 +++++++++++
 tb/tb_sample_pack_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sample_pkg.sv
// Shared types and constants for the sample packer: FSM states, lane count and lane width.
package sample_pkg;

  localparam int LANES  = 8;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/sample_pack_ctrl_tick_gen.sv
// Sample-rate divider: counts 0..CLK_DIV-1 while enabled, held at 0 otherwise.
module tick_gen #(
  parameter int CLK_DIV = 5000
) (
  input  logic clk_50mhz,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt can only reach LAST after CLK_DIV-1 enabled cycles, so no en gating is needed here.
  assign tick = (cnt == LAST);

endmodule

// File: rtl/sample_pack_ctrl.sv
// Samples an 8-channel input at a divided rate and packs LANES samples per output word.
import sample_pkg::*;

module sample_pack_ctrl #(
  parameter int CLK_DIV = 5000,
  parameter int LANES   = sample_pkg::LANES
) (
  input  logic                      clk_50mhz,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      stop,
  input  logic [BYTE_W-1:0]         sample_in,
  output logic [LANES*BYTE_W-1:0]   out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sample_tick,
  output logic                      busy,
  output logic                      overflow,
  output logic [7:0]                drop_cnt,
  output state_e                    state_dbg
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  state_e                    state, state_next;
  logic [LW-1:0]             lane_idx, lane_after;
  logic [LANES*BYTE_W-1:0]   asm_buf, asm_next;
  logic                      tick, tick_en, word_done, handshake, load, drop;

  // Output handshake: a word transfers on any rising edge where out_valid && out_ready;
  // out_valid never drops and out_data never changes until that transfer happens.
  assign word_done = tick && (lane_idx == LAST_LANE);
  assign handshake = out_valid && out_ready;
  assign load      = word_done && (!out_valid || out_ready);
  assign drop      = word_done && out_valid && !out_ready;

  // Divider is cleared on the edge that returns to IDLE so it sits at 0 for the whole idle period.
  assign tick_en = (state != IDLE) && (state_next != IDLE);

  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk_50mhz (clk_50mhz),
    .rst_n     (rst_n),
    .en        (tick_en),
    .tick      (tick)
  );

  always_comb begin
    lane_after = lane_idx;
    if (word_done) begin
      lane_after = '0;
    end else if (tick) begin
      lane_after = lane_idx + 1'b1;
    end
  end

  always_comb begin
    asm_next = asm_buf;
    if (tick) begin
      asm_next[lane_idx*BYTE_W +: BYTE_W] = sample_in;
    end
  end

  // A stop coinciding with a tick is judged on the lane index after that tick.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start && !stop) state_next = FILL;
      FILL:    if (stop) state_next = (lane_after != '0) ? DRAIN : IDLE;
      DRAIN:   if (word_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lane_idx  <= '0;
      asm_buf   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      drop_cnt  <= 8'd0;
    end else begin
      state    <= state_next;
      asm_buf  <= asm_next;
      lane_idx <= (state_next == IDLE) ? '0 : lane_after;

      if (state == IDLE && state_next == FILL) begin
        overflow <= 1'b0;
        drop_cnt <= 8'd0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end

      if (load) begin
        out_data  <= asm_next;
        out_valid <= 1'b1;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign sample_tick = tick;
  assign busy        = (state != IDLE);
  assign state_dbg   = state;

endmodule

// File: tb/tb_sample_pack_ctrl.sv
// Bench for sample_pack_ctrl with CLK_DIV=4: cycle-level reference model plus expected-word queue.
module tb_sample_pack_ctrl;
  import sample_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int NL      = 8;
  localparam int W       = 64;

  // clock / reset
  logic clk_50mhz = 1'b0;
  logic rst_n     = 1'b1;
  always #10 clk_50mhz = ~clk_50mhz;

  logic         start = 1'b0, stop = 1'b0, out_ready = 1'b0;
  logic [7:0]   sample_in = 8'd0;
  logic [W-1:0] out_data;
  logic         out_valid, sample_tick, busy, overflow;
  logic [7:0]   drop_cnt;
  state_e       state_dbg;

  sample_pack_ctrl #(.CLK_DIV(CLK_DIV), .LANES(NL)) dut (
    .clk_50mhz   (clk_50mhz),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .sample_in   (sample_in),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sample_tick (sample_tick),
    .busy        (busy),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt),
    .state_dbg   (state_dbg)
  );

  // scoreboard and reference model
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  bit m_busy = 0, m_drain = 0, m_ovf = 0;
  int m_div = 0, m_lane = 0, m_drops = 0;
  logic [W-1:0] m_word = '0;

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_busy = 0; m_drain = 0; m_ovf = 0;
    m_div = 0; m_lane = 0; m_drops = 0; m_word = '0;
  endtask

  // One clock: check outputs at negedge against the model, advance the model, end #1 after posedge.
  task automatic step(output bit t);
    bit done, was_busy;
    t = m_busy && (m_div == CLK_DIV - 1);
    @(negedge clk_50mhz);
    chk("tick",  sample_tick, t);
    chk("busy",  busy, m_busy);
    chk("valid", out_valid, exp_q.size() != 0);
    chk("ovf",   overflow, m_ovf);
    chk("drops", drop_cnt, m_drops);
    if (exp_q.size() != 0) begin
      chk("data", out_data, exp_q[0]);
      if (out_ready) void'(exp_q.pop_front());
    end
    done = 0;
    if (t) begin
      m_word[m_lane*8 +: 8] = sample_in;
      if (m_lane == NL - 1) begin
        done = 1;
        m_lane = 0;
        if (exp_q.size() != 0) begin
          m_ovf = 1;
          if (m_drops < 255) m_drops++;
        end else begin
          exp_q.push_back(m_word);
        end
      end else begin
        m_lane++;
      end
    end
    was_busy = m_busy;
    if (!m_busy) begin
      if (start && !stop) begin
        m_busy = 1; m_ovf = 0; m_drops = 0; m_lane = 0;
      end
    end else if (m_drain) begin
      if (done) begin m_busy = 0; m_drain = 0; end
    end else if (stop) begin
      if (m_lane != 0) m_drain = 1;
      else m_busy = 0;
    end
    m_div = (was_busy && m_busy) ? ((m_div == CLK_DIV - 1) ? 0 : m_div + 1) : 0;
    @(posedge clk_50mhz);
    #1;
  endtask

  // driver tasks
  task automatic idle(input int n);
    bit t;
    repeat (n) step(t);
  endtask

  task automatic pulse_start();
    bit t;
    start = 1'b1; step(t); start = 1'b0;
  endtask

  task automatic pulse_stop();
    bit t;
    stop = 1'b1; step(t); stop = 1'b0;
  endtask

  task automatic feed(input logic [7:0] b, input bit rdy_on_tick);
    bit t;
    sample_in = b;
    t = 0;
    for (int i = 0; i < CLK_DIV && !t; i++) begin
      if (rdy_on_tick && m_busy && m_div == CLK_DIV - 1) out_ready = 1'b1;
      step(t);
    end
    chk("tick_seen", t, 1);
  endtask

  task automatic feed_rand(input int n);
    for (int i = 0; i < n; i++) feed(8'($urandom_range(0, 255)), 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data, 0);
    chk("rst_tick",  sample_tick, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_ovf",   overflow, 0);
    chk("rst_drops", drop_cnt, 0);
    model_clear();
    @(posedge clk_50mhz);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    do_reset();
    idle(2);

    // basic packing
    out_ready = 1'b1;
    pulse_start();
    for (int i = 1; i <= 8; i++) feed(8'(i), 1'b0);
    chk("basic_valid", out_valid, 1);
    chk("basic_word", out_data, 64'h0807060504030201);
    pulse_stop();
    idle(3);

    // backpressure: three words, two dropped
    out_ready = 1'b0;
    pulse_start();
    feed_rand(24);
    chk("bp_ovf", overflow, 1);
    chk("bp_drops", drop_cnt, 2);
    out_ready = 1'b1;
    pulse_stop();
    idle(3);

    // stop mid-word, with a start ignored while running
    pulse_start();
    feed_rand(3);
    pulse_start();
    pulse_stop();
    feed_rand(5);
    idle(4);
    chk("stop_idle", busy, 0);

    // stop ignored in IDLE; start+stop together stays IDLE
    pulse_stop();
    idle(2);
    start = 1'b1; stop = 1'b1;
    idle(1);
    start = 1'b0; stop = 1'b0;
    idle(3);
    chk("startstop_idle", busy, 0);

    // handshake coinciding with a completing tick
    out_ready = 1'b0;
    pulse_start();
    feed_rand(15);
    feed(8'($urandom_range(0, 255)), 1'b1);
    chk("sim_valid", out_valid, 1);
    chk("sim_drops", drop_cnt, 0);
    idle(2);
    pulse_stop();
    idle(3);

    // reset mid-word with a word pending
    out_ready = 1'b0;
    pulse_start();
    feed_rand(13);
    do_reset();
    idle(3);
    out_ready = 1'b1;
    pulse_start();
    feed_rand(8);
    pulse_stop();
    idle(3);

    // drop counter saturation
    out_ready = 1'b0;
    pulse_start();
    feed_rand(300 * 8);
    chk("sat_drops", drop_cnt, 255);
    chk("sat_ovf", overflow, 1);
    out_ready = 1'b1;
    pulse_stop();
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
